flat_buffer_sequencer: RTL
==========================

FLAT_BUFFER_SEQUENCER -- requirements
Module: flat_buffer_sequencer

Interface
REQ-001 SHALL have parameter depth, default 5: number of history entries held by the controlled per-channel buffer.
REQ-002 SHALL have parameter stride_width, default 3: width of the stride configuration input.
REQ-003 SHALL have parameter fcnt_width, default 16: width of the frame counter.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rstb  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port en  input  1  enables sequencing; low forces IDLE.
REQ-007 SHALL have port flush  input  1  synchronous restart of the fill.
REQ-008 SHALL have port stride  input  stride_width  new entries accepted per emitted frame; 0 is treated as 1.
REQ-009 SHALL have port in_valid  input  1  upstream has a new entry (one word per channel).
REQ-010 SHALL have port in_ready  output  1  sequencer accepts the entry this cycle.
REQ-011 SHALL have port shift_en  output  1  buffer shift strobe; equals in_valid AND in_ready.
REQ-012 SHALL have port out_valid  output  1  flattened buffer holds a complete, stable frame.
REQ-013 SHALL have port out_ready  input  1  downstream consumes the frame.
REQ-014 SHALL have port fill_cnt  output  $clog2(depth+1)  valid entries in the buffer, 0..depth.
REQ-015 SHALL have port frame_cnt  output  fcnt_width  frames consumed, modulo 2^fcnt_width.
REQ-016 SHALL have port state  output  2  FSM state: IDLE=0, FILL=1, RUN=2.

Function
REQ-017 The FSM SHALL transition IDLE->FILL on the rising edge where en=1 and flush=0.
REQ-018 The FSM SHALL leave FILL for RUN on the accept that makes fill_cnt equal depth.
REQ-019 Any cycle with en=0 SHALL force the FSM to IDLE next cycle, with fill_cnt=0, the stride counter at 0 and out_valid=0.
REQ-020 flush=1 with en=1 SHALL force FILL next cycle, with fill_cnt=0, the stride counter at 0 and out_valid=0; flush takes priority over every other event except reset and en=0.
REQ-021 in_ready SHALL be combinational: 1 only when state!=IDLE, flush=0, en=1 and (out_valid=0 or out_ready=1).
REQ-022 In FILL, each shift_en SHALL increment fill_cnt by 1, saturating at depth.
REQ-023 out_valid SHALL be registered and SHALL rise in the cycle after the accept that brings fill_cnt to depth, which gives a one-cycle latency from the completing accept.
REQ-024 In RUN, each shift_en SHALL increment the stride counter.
REQ-025 When the stride counter reaches the effective stride, out_valid SHALL rise next cycle and the stride counter SHALL return to 0.
REQ-026 The effective stride SHALL be max(stride,1), latched when out_valid rises; a stride change has no effect on the frame already in progress.
REQ-027 While out_valid=1 and out_ready=0, out_valid SHALL hold 1, in_ready SHALL be 0 and shift_en SHALL be 0, so the buffer contents stay frozen.
REQ-028 On out_valid=1 and out_ready=1, out_valid SHALL clear next cycle unless the same-cycle accept completes the next frame, in which case out_valid SHALL stay 1.
REQ-029 In the same handshake cycle, frame_cnt SHALL increment by 1 and wrap from 2^fcnt_width-1 to 0.
REQ-030 A simultaneous frame consume and entry accept SHALL both take effect in that cycle.
REQ-031 out_ready with out_valid=0 SHALL be ignored.
REQ-032 in_valid with in_ready=0 SHALL cause no state change.

Reset
REQ-033 While rstb=0, the block SHALL set state=IDLE, fill_cnt=0, stride counter=0, out_valid=0 and frame_cnt=0 immediately, independent of clk.
REQ-034 While rstb=0, in_ready and shift_en SHALL be 0.
REQ-035 Deassertion of rstb SHALL take effect at the next clk edge; the first transition after reset SHALL follow REQ-017.
REQ-036 Reset asserted mid-frame SHALL discard the partial fill and any pending frame.

Verification
REQ-037 Fill: depth=5, en=1, stride=1, in_valid held 1, out_ready=1 -> fill_cnt counts 1..5, state=RUN after the 5th accept, out_valid high one cycle later, then out_valid high every cycle and frame_cnt incrementing per cycle.
REQ-038 Backpressure: in RUN with out_valid=1, hold out_ready=0 for 4 cycles -> in_ready=0, shift_en=0, fill_cnt=5 and frame_cnt unchanged for those cycles; release -> frame_cnt +1.
REQ-039 Stride: stride=3, in_valid continuous, out_ready=1 -> after the fill, out_valid pulses once per 3 accepts; stride=0 -> behaves as stride=1.
REQ-040 Flush: flush pulsed with fill_cnt=5 and out_valid=1 -> next cycle state=FILL, fill_cnt=0, out_valid=0, and five further accepts are required before out_valid rises.
REQ-041 Async reset: rstb pulled low between clk edges during RUN -> all outputs reach reset values before the next edge; frame_cnt=0.
REQ-042 Wrap: fcnt_width=4 with 17 frames consumed -> frame_cnt reads 0 after the 16th frame and 1 after the 17th.

Source files
------------

// File: rtl/flat_buffer_sequencer_if.sv
// Handshake bundle between the sequencer, its upstream source and the
// downstream frame consumer.
interface flat_buffer_sequencer_if;
    logic in_valid;
    logic in_ready;
    logic shift_en;
    logic out_valid;
    logic out_ready;

    modport master (
        output in_valid,
        output out_ready,
        input  in_ready,
        input  shift_en,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  out_ready,
        output in_ready,
        output shift_en,
        output out_valid
    );
endinterface

// File: rtl/flat_buffer_sequencer.sv
// Controls a per-channel history buffer: fills it, then emits a frame
// every effective-stride accepts, freezing the buffer under backpressure.
module flat_buffer_sequencer #(
    parameter int depth        = 5,
    parameter int stride_width = 3,
    parameter int fcnt_width   = 16
) (
    input  logic                         clk,
    input  logic                         rstb,
    input  logic                         en,
    input  logic                         flush,
    input  logic [stride_width-1:0]      stride,
    flat_buffer_sequencer_if.slave       bus,
    output logic [$clog2(depth+1)-1:0]   fill_cnt,
    output logic [fcnt_width-1:0]        frame_cnt,
    output logic [1:0]                   state
);

    localparam int FW = $clog2(depth + 1);
    localparam int SW = stride_width;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [FW-1:0]         fill_q, fill_d;
    logic [SW-1:0]         scnt_q, scnt_d;
    logic [SW-1:0]         str_q, str_d;
    logic                  ov_q, ov_d;
    logic [fcnt_width-1:0] fcnt_q, fcnt_d;

    logic          in_rdy;
    logic          shift;
    logic          consume;
    logic [SW-1:0] eff;

    always_comb begin
        in_rdy  = (state_q != IDLE) & en & ~flush & (~ov_q | bus.out_ready);
        shift   = bus.in_valid & in_rdy;
        consume = ov_q & bus.out_ready;
        eff     = (stride == '0) ? SW'(1) : stride;

        state_d = state_q;
        fill_d  = fill_q;
        scnt_d  = scnt_q;
        str_d   = str_q;
        ov_d    = ov_q;
        fcnt_d  = fcnt_q;

        if (!en) begin
            state_d = IDLE;
            fill_d  = '0;
            scnt_d  = '0;
            ov_d    = 1'b0;
        end else if (flush) begin
            state_d = FILL;
            fill_d  = '0;
            scnt_d  = '0;
            ov_d    = 1'b0;
        end else begin
            if (consume) begin
                ov_d   = 1'b0;
                fcnt_d = fcnt_q + fcnt_width'(1);
            end
            unique case (state_q)
                IDLE: state_d = FILL;
                FILL: begin
                    if (shift) begin
                        fill_d = fill_q + FW'(1);
                        if (fill_q == FW'(depth - 1)) begin
                            state_d = RUN;
                            ov_d    = 1'b1;
                            str_d   = eff;
                        end
                    end
                end
                RUN: begin
                    // Stride is re-latched at every frame completion
                    if (shift) begin
                        if ((scnt_q + SW'(1)) >= str_q) begin
                            scnt_d = '0;
                            ov_d   = 1'b1;
                            str_d  = eff;
                        end else begin
                            scnt_d = scnt_q + SW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
            fill_q  <= '0;
            scnt_q  <= '0;
            str_q   <= SW'(1);
            ov_q    <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            scnt_q  <= scnt_d;
            str_q   <= str_d;
            ov_q    <= ov_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.shift_en  = shift;
    assign bus.out_valid = ov_q;
    assign fill_cnt      = fill_q;
    assign frame_cnt     = fcnt_q;
    assign state         = state_q;

endmodule
